// File: rtl/result_frame_tx.sv
// ---------------------------------------------------------------------------
// result_frame_tx
//
// Transmit side of the accelerator's 8-bit byte interface. Result pairs
// (channel 0 / channel 1) coming out of the last layer are captured into a
// frame buffer, one pair per conv output position. When N_POS pairs have
// been captured, the frame is streamed out over a valid/ready byte
// handshake as:
//
//   HEADER, LEN = (2*N_POS) mod 256, payload[0 .. 2*N_POS-1], CHECKSUM
//
// The payload order is ch0,ch1 of position 0, then position 1, and so on.
// CHECKSUM is the 8-bit modular sum of the payload bytes only.
// The checksum is accumulated while pairs are captured, so it is ready
// the moment the payload has been sent.
//
// Ports
//   clk         in   1  clock
//   reset       in   1  synchronous, active-high reset (priority over all)
//   ena         in   1  global enable; 0 freezes all state and outputs
//   in_valid    in   1  result pair present this cycle
//   in_data_0   in   8  channel-0 result
//   in_data_1   in   8  channel-1 result
//   tx_ready    in   1  host accepts tx_data this cycle
//   tx_data     out  8  current frame byte
//   tx_valid    out  1  tx_data valid
//   tx_last     out  1  high with the checksum byte
//   busy        out  1  high while a frame is being sent
//   frame_done  out  1  one-cycle pulse after the checksum byte is accepted
//   overrun     out  1  sticky: a pair arrived while a frame was being sent
// ---------------------------------------------------------------------------
module result_frame_tx #(
  parameter int          N_POS  = 36,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       in_valid,
  input  logic [7:0] in_data_0,
  input  logic [7:0] in_data_1,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_last,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int N_BYTES = 2 * N_POS;
  localparam int PTR_W   = (N_POS > 1) ? $clog2(N_POS) : 1;
  localparam int IDX_W   = $clog2(N_BYTES);

  localparam logic [7:0]       LEN_BYTE = 8'(N_BYTES % 256);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_POS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_SEND_HDR,
    S_SEND_LEN,
    S_SEND_DATA,
    S_SEND_CSUM
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t           r_state;
  logic [PTR_W-1:0] r_wr_ptr;       // next pair position to capture
  logic [IDX_W-1:0] r_rd_idx;       // next payload byte to send
  logic [7:0]       r_csum;         // running payload sum
  logic             r_overrun;
  logic             r_frame_done;
  logic [7:0]       r_buf [N_BYTES];

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  state_t           w_state_next;
  logic             w_capture;      // pair written into the buffer this cycle
  logic             w_accept;       // byte handshake completes this cycle
  logic             w_csum_accept;  // checksum byte handshake this cycle
  logic             w_data_accept;  // payload byte handshake this cycle
  logic [IDX_W-1:0] w_wr_idx_lo;    // buffer slot for channel 0
  logic [IDX_W-1:0] w_wr_idx_hi;    // buffer slot for channel 1

  // Pair p lands at bytes 2p and 2p+1.
  assign w_wr_idx_lo = IDX_W'({r_wr_ptr, 1'b0});
  assign w_wr_idx_hi = IDX_W'({r_wr_ptr, 1'b1});

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_COLLECT;
    end else if (ena) begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  // The byte outputs are decoded from registered state only, so they hold
  // stable for as long as the state holds (tx_ready low or ena low).
  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    tx_last      = 1'b0;
    busy         = 1'b0;

    unique case (r_state)
      S_COLLECT: begin
        w_capture = in_valid;
        if (in_valid && (r_wr_ptr == LAST_PTR)) begin
          w_state_next = S_SEND_HDR;
        end
      end

      S_SEND_HDR: begin
        tx_data  = HEADER;
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (tx_ready) begin
          w_state_next = S_SEND_LEN;
        end
      end

      S_SEND_LEN: begin
        tx_data  = LEN_BYTE;
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (tx_ready) begin
          w_state_next = S_SEND_DATA;
        end
      end

      S_SEND_DATA: begin
        tx_data  = r_buf[r_rd_idx];
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (tx_ready && (r_rd_idx == LAST_IDX)) begin
          w_state_next = S_SEND_CSUM;
        end
      end

      S_SEND_CSUM: begin
        tx_data  = r_csum;
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        busy     = 1'b1;
        if (tx_ready) begin
          w_state_next = S_COLLECT;
        end
      end

      default: begin
        w_state_next = S_COLLECT;
      end
    endcase
  end

  assign w_accept      = tx_valid & tx_ready;
  assign w_data_accept = w_accept & (r_state == S_SEND_DATA);
  assign w_csum_accept = w_accept & (r_state == S_SEND_CSUM);

  // -------------------------------------------------------------------------
  // Datapath: pointers, checksum, status flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_idx     <= '0;
      r_csum       <= '0;
      r_overrun    <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (ena) begin
      r_frame_done <= w_csum_accept;

      // Any pair offered outside COLLECT is dropped, including one that
      // coincides with the checksum handshake.
      if (in_valid && (r_state != S_COLLECT)) begin
        r_overrun <= 1'b1;
      end

      if (w_capture) begin
        r_csum   <= r_csum + in_data_0 + in_data_1;
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_ONE;
      end

      // Wrap to 0 on the last payload byte so the next frame starts clean.
      if (w_data_accept) begin
        r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + IDX_ONE;
      end

      // Capture only happens in COLLECT, so this never races the add above.
      if (w_csum_accept) begin
        r_csum <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Frame buffer
  // -------------------------------------------------------------------------
  // NOTE: the buffer has no reset; every byte is written before it is read,
  // so leaving it out keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (ena && w_capture) begin
      r_buf[w_wr_idx_lo] <= in_data_0;
      r_buf[w_wr_idx_hi] <= in_data_1;
    end
  end

  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule
